// File: rtl/smart_toilet_dispense_ctrl.sv
// smart_toilet_dispense_ctrl
//   Timed valve sequencer for one assay run of the smart_toilet fluidic netlist:
//   DOSE12 (soln1+soln2) -> DOSE3 (soln3) -> HOLD (all closed) -> FLUSH.
//   Zero-length phases are skipped. Abort during a dose/hold phase diverts to FLUSH.
//   Optional feature macro: SMART_TOILET_PRESSURE_FAULT_EN (adds pressure_ok/fault
//   and a FAULT state that is left only via rst_n).
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   start, abort                 host handshake requests
//   dose12/dose3/hold/flush_cyc  phase lengths, latched at start accept
//   valve_soln1..3, valve_flush  registered valve drives
//   busy, done, aborted          host status
//   run_count                    completed non-aborted runs (wraps)
module smart_toilet_dispense_ctrl #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned RUN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] dose12_cyc,
   input  logic [CNT_W-1:0] dose3_cyc,
   input  logic [CNT_W-1:0] hold_cyc,
   input  logic [CNT_W-1:0] flush_cyc,
`ifdef SMART_TOILET_PRESSURE_FAULT_EN
   input  logic             pressure_ok,
   output logic             fault,
`endif
   output logic             valve_soln1,
   output logic             valve_soln2,
   output logic             valve_soln3,
   output logic             valve_flush,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [RUN_W-1:0] run_count
);

   // Encoding order matters: first_phase relies on DOSE12 < DOSE3 < HOLD < FLUSH.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DOSE12 = 3'd1;
   localparam logic [2:0] ST_DOSE3  = 3'd2;
   localparam logic [2:0] ST_HOLD   = 3'd3;
   localparam logic [2:0] ST_FLUSH  = 3'd4;
`ifdef SMART_TOILET_PRESSURE_FAULT_EN
   localparam logic [2:0] ST_FAULT  = 3'd5;
`endif

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

   logic [2:0]       state_q, state_d, nxt;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] d12_q, d12_d, d3_q, d3_d, dh_q, dh_d, df_q, df_d;
   logic             done_q, done_d, aborted_q, aborted_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             v12_q, v3_q, vfl_q, busy_q;
`ifdef SMART_TOILET_PRESSURE_FAULT_EN
   logic [1:0]       lo_q, lo_d;
   logic             fault_q;
`endif

   // First phase strictly after 'after' whose length is nonzero; IDLE if none.
   function automatic logic [2:0] first_phase(input logic [2:0] after,
                                               input logic [CNT_W-1:0] a, b, c, d);
      first_phase = ST_IDLE;
      if (after < ST_FLUSH  && d != '0) first_phase = ST_FLUSH;
      if (after < ST_HOLD   && c != '0) first_phase = ST_HOLD;
      if (after < ST_DOSE3  && b != '0) first_phase = ST_DOSE3;
      if (after < ST_DOSE12 && a != '0) first_phase = ST_DOSE12;
   endfunction

   function automatic logic [CNT_W-1:0] phase_len(input logic [2:0] st,
                                                   input logic [CNT_W-1:0] a, b, c, d);
      case (st)
         ST_DOSE12: phase_len = a;
         ST_DOSE3:  phase_len = b;
         ST_HOLD:   phase_len = c;
         ST_FLUSH:  phase_len = d;
         default:   phase_len = CNT_ONE;
      endcase
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      d12_d     = d12_q;
      d3_d      = d3_q;
      dh_d      = dh_q;
      df_d      = df_q;
      done_d    = 1'b0;
      aborted_d = aborted_q;
      run_d     = run_q;
      nxt       = ST_IDLE;
      case (state_q)
         ST_IDLE: begin
            // abort beats start in IDLE: no run begins
            if (start && !abort) begin
               d12_d     = dose12_cyc;
               d3_d      = dose3_cyc;
               dh_d      = hold_cyc;
               df_d      = flush_cyc;
               aborted_d = 1'b0;
               nxt       = first_phase(ST_IDLE, dose12_cyc, dose3_cyc, hold_cyc, flush_cyc);
               state_d   = nxt;
               if (nxt == ST_IDLE) begin
                  done_d = 1'b1;
                  run_d  = run_q + RUN_ONE;
                  cnt_d  = '0;
               end else begin
                  cnt_d = phase_len(nxt, dose12_cyc, dose3_cyc, hold_cyc, flush_cyc) - CNT_ONE;
               end
            end
         end
         ST_DOSE12, ST_DOSE3, ST_HOLD: begin
            if (abort) begin
               aborted_d = 1'b1;
               if (df_q != '0) begin
                  state_d = ST_FLUSH;
                  cnt_d   = df_q - CNT_ONE;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end
            end else if (cnt_q == '0) begin
               nxt     = first_phase(state_q, d12_q, d3_q, dh_q, df_q);
               state_d = nxt;
               if (nxt == ST_IDLE) begin
                  done_d = 1'b1;
                  run_d  = run_q + RUN_ONE;
                  cnt_d  = '0;
               end else begin
                  cnt_d = phase_len(nxt, d12_q, d3_q, dh_q, df_q) - CNT_ONE;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               if (!aborted_q) run_d = run_q + RUN_ONE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
`ifdef SMART_TOILET_PRESSURE_FAULT_EN
         ST_FAULT: ;
`endif
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

`ifdef SMART_TOILET_PRESSURE_FAULT_EN
      // Four consecutive low samples inside a dose phase latch FAULT; it overrides
      // any abort/advance decided above.
      lo_d = '0;
      if ((state_q == ST_DOSE12 || state_q == ST_DOSE3) && !pressure_ok) begin
         if (lo_q == 2'd3) begin
            state_d   = ST_FAULT;
            cnt_d     = '0;
            done_d    = 1'b0;
            run_d     = run_q;
            aborted_d = aborted_q;
         end else begin
            lo_d = lo_q + 2'd1;
         end
      end
      if (state_d != state_q) lo_d = '0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         d12_q     <= '0;
         d3_q      <= '0;
         dh_q      <= '0;
         df_q      <= '0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         run_q     <= '0;
         v12_q     <= 1'b0;
         v3_q      <= 1'b0;
         vfl_q     <= 1'b0;
         busy_q    <= 1'b0;
`ifdef SMART_TOILET_PRESSURE_FAULT_EN
         lo_q      <= '0;
         fault_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         d12_q     <= d12_d;
         d3_q      <= d3_d;
         dh_q      <= dh_d;
         df_q      <= df_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         run_q     <= run_d;
         // Outputs decoded from next state so valves switch on the state edge.
         v12_q     <= (state_d == ST_DOSE12);
         v3_q      <= (state_d == ST_DOSE3);
         vfl_q     <= (state_d == ST_FLUSH);
         busy_q    <= (state_d != ST_IDLE);
`ifdef SMART_TOILET_PRESSURE_FAULT_EN
         lo_q      <= lo_d;
         fault_q   <= (state_d == ST_FAULT);
`endif
      end
   end

   assign valve_soln1 = v12_q;
   assign valve_soln2 = v12_q;
   assign valve_soln3 = v3_q;
   assign valve_flush = vfl_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign aborted     = aborted_q;
   assign run_count   = run_q;
`ifdef SMART_TOILET_PRESSURE_FAULT_EN
   assign fault       = fault_q;
`endif

endmodule

// File: tb/tb_smart_toilet_dispense_ctrl.sv
// Bench for smart_toilet_dispense_ctrl: a schedule-queue reference model (one entry
// per cycle of expected outputs, built when a run is accepted) compared every cycle,
// plus directed runs with hand-computed expectations.
module tb_smart_toilet_dispense_ctrl;

   localparam int CNT_W = 16;
   localparam int RUN_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [CNT_W-1:0] dose12_cyc = '0, dose3_cyc = '0, hold_cyc = '0, flush_cyc = '0;
   logic             valve_soln1, valve_soln2, valve_soln3, valve_flush;
   logic             busy, done, aborted;
   logic [RUN_W-1:0] run_count;
`ifdef SMART_TOILET_PRESSURE_FAULT_EN
   logic             fault;
`endif

   smart_toilet_dispense_ctrl #(.CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .dose12_cyc  (dose12_cyc),
      .dose3_cyc   (dose3_cyc),
      .hold_cyc    (hold_cyc),
      .flush_cyc   (flush_cyc),
`ifdef SMART_TOILET_PRESSURE_FAULT_EN
      .pressure_ok (1'b1),
      .fault       (fault),
`endif
      .valve_soln1 (valve_soln1),
      .valve_soln2 (valve_soln2),
      .valve_soln3 (valve_soln3),
      .valve_flush (valve_flush),
      .busy        (busy),
      .done        (done),
      .aborted     (aborted),
      .run_count   (run_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic s12, s3, hd, fl, busy, done, inc;
   } rec_t;

   rec_t             cur;
   rec_t             sched[$];
   logic             m_aborted;
   logic [RUN_W-1:0] m_run;
   int               lat_f;

   task automatic push_n(input rec_t r, input int n);
      for (int i = 0; i < n; i++) sched.push_back(r);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur = '0;
         sched.delete();
         m_aborted = 1'b0;
         m_run = '0;
      end else begin
         if (!cur.busy) begin
            if (start && !abort) begin
               sched.delete();
               lat_f = int'(flush_cyc);
               push_n('{s12:1, s3:0, hd:0, fl:0, busy:1, done:0, inc:0}, int'(dose12_cyc));
               push_n('{s12:0, s3:1, hd:0, fl:0, busy:1, done:0, inc:0}, int'(dose3_cyc));
               push_n('{s12:0, s3:0, hd:1, fl:0, busy:1, done:0, inc:0}, int'(hold_cyc));
               push_n('{s12:0, s3:0, hd:0, fl:1, busy:1, done:0, inc:0}, lat_f);
               push_n('{s12:0, s3:0, hd:0, fl:0, busy:0, done:1, inc:1}, 1);
               m_aborted = 1'b0;
            end
         end else if (abort && (cur.s12 || cur.s3 || cur.hd)) begin
            sched.delete();
            push_n('{s12:0, s3:0, hd:0, fl:1, busy:1, done:0, inc:0}, lat_f);
            push_n('{s12:0, s3:0, hd:0, fl:0, busy:0, done:1, inc:0}, 1);
            m_aborted = 1'b1;
         end
         if (sched.size() > 0) cur = sched.pop_front();
         else cur = '0;
         if (cur.done && cur.inc) m_run = m_run + 1'b1;
      end
   end

   // One compare per cycle while out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("cycle_outputs",
             {valve_soln1, valve_soln2, valve_soln3, valve_flush, busy, done, aborted, run_count},
             {cur.s12, cur.s12, cur.s3, cur.fl, cur.busy, cur.done, m_aborted, m_run});
      end
   end

   // ---------------- directed helper ----------------
   int c12, c3, chold, cfl, kdone, kfl;

   // Called just after a negedge with the DUT idle. Samples n cycles after the accept
   // edge; abort is raised for the edge following sample abort_k; start stays high for
   // start_hold extra edges while the durations are scrambled.
   task automatic run_directed(input int a, input int b, input int c, input int d,
                               input int abort_k, input int start_hold, input int n);
      dose12_cyc = CNT_W'(a);
      dose3_cyc  = CNT_W'(b);
      hold_cyc   = CNT_W'(c);
      flush_cyc  = CNT_W'(d);
      start = 1'b1;
      abort = 1'b0;
      c12 = 0; c3 = 0; chold = 0; cfl = 0; kdone = -1; kfl = -1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         start = (k < start_hold);
         dose12_cyc = CNT_W'(7);
         dose3_cyc  = CNT_W'(7);
         hold_cyc   = CNT_W'(7);
         flush_cyc  = CNT_W'(7);
         abort = (k == abort_k);
         if (valve_soln1 && valve_soln2) c12++;
         if (valve_soln3) c3++;
         if (busy && !valve_soln1 && !valve_soln3 && !valve_flush) chold++;
         if (valve_flush) begin
            cfl++;
            if (kfl < 0) kfl = k;
         end
         if (done && kdone < 0) kdone = k;
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_valves", {valve_soln1, valve_soln2, valve_soln3, valve_flush}, 0);
      chk("reset_status", {busy, done, aborted, run_count}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Normal run 3,2,4,5.
      run_directed(3, 2, 4, 5, -1, 0, 16);
      chk("t1_soln12_cycles", c12, 3);
      chk("t1_soln3_cycles", c3, 2);
      chk("t1_hold_cycles", chold, 4);
      chk("t1_flush_cycles", cfl, 5);
      chk("t1_done_index", kdone, 14);
      chk("t1_run_count", run_count, 1);

      // Skipped phases 0,2,0,1.
      run_directed(0, 2, 0, 1, -1, 0, 5);
      chk("t2_soln12_cycles", c12, 0);
      chk("t2_soln3_cycles", c3, 2);
      chk("t2_flush_first", kfl, 2);
      chk("t2_done_index", kdone, 3);

      // Abort in 2nd cycle of DOSE3.
      run_directed(1, 3, 2, 4, 2, 0, 9);
      chk("t3_soln3_cycles", c3, 2);
      chk("t3_hold_cycles", chold, 0);
      chk("t3_flush_first", kfl, 3);
      chk("t3_flush_cycles", cfl, 4);
      chk("t3_done_index", kdone, 7);
      chk("t3_aborted", aborted, 1);
      chk("t3_run_count", run_count, 2);

      // start+abort in IDLE: nothing begins.
      dose12_cyc = CNT_W'(3);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("t4_no_run_busy", busy, 0);
      chk("t4_no_run_valve", valve_soln1, 0);

      // start held during busy with changed durations: ignored.
      run_directed(2, 0, 0, 0, -1, 1, 4);
      chk("t4_soln12_cycles", c12, 2);
      chk("t4_done_index", kdone, 2);
      chk("t4_aborted_cleared", aborted, 0);
      chk("t4_run_count", run_count, 3);

      // Reset mid-DOSE12 drops valves asynchronously.
      dose12_cyc = CNT_W'(5);
      dose3_cyc  = '0;
      hold_cyc   = '0;
      flush_cyc  = CNT_W'(2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("t5_pre_reset_valve", valve_soln1, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_valves", {valve_soln1, valve_soln2, valve_soln3, valve_flush}, 0);
      chk("t5_async_busy", busy, 0);
      chk("t5_async_count", run_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_no_flush", valve_flush, 0);

      // 256 back-to-back all-zero runs: run_count wraps.
      dose12_cyc = '0;
      dose3_cyc  = '0;
      hold_cyc   = '0;
      flush_cyc  = '0;
      start = 1'b1;
      for (int i = 1; i <= 256; i++) begin
         @(negedge clk);
         if (i == 1) chk("t6_zero_done", done, 1);
         if (i == 255) chk("t6_count_255", run_count, 255);
      end
      start = 1'b0;
      chk("t6_wrap", run_count, 0);

      // Randomized traffic checked by the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start      = ($urandom_range(0, 3) == 0);
         abort      = ($urandom_range(0, 19) == 0);
         dose12_cyc = CNT_W'($urandom_range(0, 4));
         dose3_cyc  = CNT_W'($urandom_range(0, 4));
         hold_cyc   = CNT_W'($urandom_range(0, 3));
         flush_cyc  = CNT_W'($urandom_range(0, 3));
      end
      start = 1'b0;
      abort = 1'b0;
      begin
         int budget;
         budget = 0;
         while (busy && budget < 200) begin
            @(negedge clk);
            budget++;
         end
         chk("final_idle_timeout", busy, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/smart_toilet_dispense_ctrl.md
Name: smart_toilet_dispense_ctrl

Overview:
- Clocked valve/pump sequencer directly upstream of the smart_toilet fluidic netlist.
- Drives the inlet valves that admit soln1, soln2 and soln3, then a flush valve, in a fixed timed sequence per assay run.
- soln1 and soln2 are admitted together because they converge at the first diffusion mixer; soln3 follows on its own long serpentine path.
- Host handshake is start/busy/done, with an abort path that always ends in a flush.

Parameters:
CNT_W, 16, width of phase duration inputs and the internal phase counter
RUN_W, 8, width of completed-run counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a run; sampled only in IDLE
abort  in  1  terminate the current run early
dose12_cyc  in  CNT_W  cycles with soln1+soln2 valves open; latched at start accept
dose3_cyc  in  CNT_W  cycles with soln3 valve open; latched at start accept
hold_cyc  in  CNT_W  mix-settle cycles, all valves closed; latched at start accept
flush_cyc  in  CNT_W  flush valve open cycles; latched at start accept
valve_soln1  out  1  open soln1 inlet
valve_soln2  out  1  open soln2 inlet
valve_soln3  out  1  open soln3 inlet
valve_flush  out  1  open flush inlet
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at normal or aborted completion
aborted  out  1  sticky; set by abort, cleared on next start accept
run_count  out  RUN_W  completed (non-aborted) runs, wraps modulo 2^RUN_W

Behaviour:
- Reset (async assert, sync release): state IDLE, all valves 0, busy 0, done 0, aborted 0, run_count 0, counter 0. Reset mid-run closes all valves immediately and performs no flush.
- All outputs are registered and decoded from the next-state value, so valves change on the same edge as the state.
- States: IDLE, DOSE12, DOSE3, HOLD, FLUSH.
- Active outputs per state:
  - DOSE12: valve_soln1 = valve_soln2 = 1.
  - DOSE3: valve_soln3 = 1.
  - HOLD: no valves open.
  - FLUSH: valve_flush = 1.
  - At most one valve group is open in any cycle.
- Start accept: in IDLE with start=1 and abort=0.
  - Latch all four durations, clear aborted.
  - Enter the first phase with a nonzero duration, in order DOSE12 -> DOSE3 -> HOLD -> FLUSH.
- Phase timing:
  - On phase entry, counter = duration-1; it decrements each cycle.
  - Leave the phase when counter==0, going to the next phase with nonzero duration.
  - A phase with duration N keeps its outputs active for exactly N cycles.
  - Duration 0 skips the phase entirely with no idle cycle inserted.
- All four durations 0 at start: no valve opens; done pulses the cycle after start; run_count increments; return to IDLE.
- Normal completion: after the last nonzero phase ends, return to IDLE, done=1 for one cycle, run_count+1.
- Abort:
  - abort=1 in DOSE12, DOSE3 or HOLD: next state FLUSH with counter = latched flush_cyc-1; aborted set.
  - If latched flush_cyc==0, go straight to IDLE instead.
  - The aborted run still pulses done but does not increment run_count.
  - abort in FLUSH or IDLE is ignored.
  - abort and start together in IDLE: abort wins, no run begins.
- start while busy: ignored. Duration input changes while busy: ignored.
- run_count wraps from 2^RUN_W-1 to 0 without a flag.

Optional Feature:
- Macro: SMART_TOILET_PRESSURE_FAULT_EN.
- When defined:
  - Adds input pressure_ok (1) and output fault (1, reset 0).
  - In DOSE12 or DOSE3, pressure_ok=0 for 4 consecutive cycles moves the block to a FAULT state: all valves 0, busy 1, fault 1, no done pulse.
  - FAULT is left only via rst_n. The consecutive-low counter clears on any pressure_ok=1 cycle and on phase change.
- When undefined: ports are absent, the FAULT state does not exist, and behaviour is exactly as above.

Test Plan:
- Normal run, durations 3,2,4,5 → valve_soln1/2 high 3 cycles, soln3 2, none 4, flush 5; done pulses on cycle 15 after start; run_count=1.
- Durations 0,2,0,1 → DOSE12 and HOLD skipped: soln3 high 2 cycles then flush 1 cycle, no gap; done after 3 cycles.
- Abort in 2nd cycle of DOSE3 with flush_cyc=4 → soln3 drops next edge, flush high 4 cycles, aborted=1, done pulses, run_count unchanged.
- start+abort in IDLE, then start during busy → no run from the first; second start ignored; reset mid-DOSE12 → all valves 0 asynchronously.
- 256 all-zero runs with RUN_W=8 → run_count wraps to 0.
- With SMART_TOILET_PRESSURE_FAULT_EN: pressure_ok low 3 cycles then high → no fault; low 4 consecutive cycles in DOSE12 → fault=1, valves 0, held until rst_n.
